// File: rtl/corr_pkg.sv
// Shared types for the correlation lag sweeper: FSM states, the lag tag carried
// alongside the correlator pipeline, and the lag-count helper.
package corr_pkg;

  // Upper bound on lag width carried in a tag; C_WIDTH must not exceed it.
  localparam int TAG_LAG_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sweep_state_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_LAG_W-1:0] lag;
  } lag_tag_t;

  function automatic int nlags(input int width);
    return 2 * width - 1;
  endfunction

endpackage

// File: rtl/corr_tag_pipe.sv
// DEPTH-stage shift register of lag tags, aligned with the correlator latency.
// A synchronous clear empties every stage.
module corr_tag_pipe
  import corr_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clk,
  input  logic     clear,
  input  lag_tag_t din,
  output lag_tag_t dout
);

  lag_tag_t stages [DEPTH];

  // tag delay line
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/corr_lag_sweeper.sv
// Drives a per-lag correlator through lags 0..2*WIDTH-2 and tracks the peak result.
// Optional per-lag result stream is enabled by defining CORR_STREAM_EN.
module corr_lag_sweeper
  import corr_pkg::*;
#(
  parameter int WIDTH   = 256,
  parameter int C_WIDTH = 9,
  parameter int LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [C_WIDTH-1:0] count,
  input  logic [WIDTH-1:0]   corr_in,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   peak_val,
  output logic [C_WIDTH-1:0] peak_lag
`ifdef CORR_STREAM_EN
  ,
  output logic               res_valid,
  output logic [C_WIDTH-1:0] res_lag,
  output logic [WIDTH-1:0]   res_data
`endif
);

  localparam int                 NLAGS      = nlags(WIDTH);
  localparam logic [C_WIDTH-1:0] LAST_LAG   = C_WIDTH'(NLAGS - 1);
  localparam int                 DW         = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [DW-1:0]      DRAIN_LAST = DW'(LATENCY - 1);

  if ((64'd1 << C_WIDTH) < 64'(NLAGS)) begin : g_bad_cwidth
    $error("corr_lag_sweeper: C_WIDTH too small for 2*WIDTH-1 lags");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("corr_lag_sweeper: LATENCY must be at least 1");
  end
  if (C_WIDTH > TAG_LAG_W) begin : g_bad_tag
    $error("corr_lag_sweeper: C_WIDTH exceeds tag lag width");
  end

  sweep_state_t       state;
  sweep_state_t       next_state;
  logic [DW-1:0]      drain_cnt;
  lag_tag_t           pipe_in;
  lag_tag_t           pipe_out;
  logic               cap_valid;
  logic [C_WIDTH-1:0] cap_lag;
  logic               first_cap;
  logic               unused_tag_bits;

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = start ? ISSUE : IDLE;
      ISSUE:   next_state = (count == LAST_LAG) ? DRAIN : ISSUE;
      DRAIN:   next_state = (drain_cnt == DRAIN_LAST) ? DONE : DRAIN;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ISSUE:   busy = 1'b1;
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // lag counter and drain timer; count parks on the last lag until DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          count     <= '0;
          drain_cnt <= '0;
        end
        ISSUE: begin
          if (count != LAST_LAG) begin
            count <= count + C_WIDTH'(1);
          end else begin
            count <= count;
          end
          drain_cnt <= '0;
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + DW'(1);
        end
        DONE: begin
          count     <= '0;
          drain_cnt <= '0;
        end
        default: begin
          count     <= '0;
          drain_cnt <= '0;
        end
      endcase
    end
  end

  // tag entering the delay line alongside each issued lag
  always_comb begin
    pipe_in       = '0;
    pipe_in.valid = (state == ISSUE);
    pipe_in.lag   = TAG_LAG_W'(count);
  end

  corr_tag_pipe #(
    .DEPTH (LATENCY)
  ) u_tag_pipe (
    .clk   (clk),
    .clear (reset),
    .din   (pipe_in),
    .dout  (pipe_out)
  );

  assign cap_valid       = pipe_out.valid;
  assign cap_lag         = pipe_out.lag[C_WIDTH-1:0];
  assign unused_tag_bits = ^pipe_out.lag;

  // peak tracking: first capture loads, later ones only on a strictly larger value
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_val  <= '0;
      peak_lag  <= '0;
      first_cap <= 1'b0;
    end else if (state == IDLE && start) begin
      first_cap <= 1'b1;
    end else if (cap_valid) begin
      if (first_cap || (corr_in > peak_val)) begin
        peak_val <= corr_in;
        peak_lag <= cap_lag;
      end
      first_cap <= 1'b0;
    end
  end

`ifdef CORR_STREAM_EN
  // per-lag result stream, registered alongside the peak update
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_lag   <= '0;
      res_data  <= '0;
    end else begin
      res_valid <= cap_valid;
      if (cap_valid) begin
        res_lag  <= cap_lag;
        res_data <= corr_in;
      end
    end
  end
`endif

endmodule

// File: tb/tb_corr_lag_sweeper.sv
// Directed bench for corr_lag_sweeper with a registered correlator model
// (WIDTH=8, LATENCY=1, 15 lags).
module tb_corr_lag_sweeper;

  localparam int WIDTH   = 8;
  localparam int C_WIDTH = 4;
  localparam int LATENCY = 1;

  logic               clk;
  logic               reset;
  logic               start;
  logic [C_WIDTH-1:0] count;
  logic [WIDTH-1:0]   corr_in;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   peak_val;
  logic [C_WIDTH-1:0] peak_lag;
`ifdef CORR_STREAM_EN
  logic               res_valid;
  logic [C_WIDTH-1:0] res_lag;
  logic [WIDTH-1:0]   res_data;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int mode  = 0;
  int n_res = 0;

  corr_lag_sweeper #(
    .WIDTH   (WIDTH),
    .C_WIDTH (C_WIDTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .count    (count),
    .corr_in  (corr_in),
    .busy     (busy),
    .done     (done),
    .peak_val (peak_val),
    .peak_lag (peak_lag)
`ifdef CORR_STREAM_EN
    ,
    .res_valid (res_valid),
    .res_lag   (res_lag),
    .res_data  (res_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode 0: triangle 3*min(k,14-k); 1: constant 5; 2: spike 200 at lag 14
  function automatic logic [WIDTH-1:0] model(input int m, input int k);
    int v;
    case (m)
      0:       v = 3 * ((k < 14 - k) ? k : 14 - k);
      1:       v = 5;
      2:       v = (k == 14) ? 200 : 0;
      default: v = 0;
    endcase
    return WIDTH'(v);
  endfunction

  always @(posedge clk) corr_in <= model(mode, int'(count));

  // launch one sweep and observe 30 cycles; optional extra start pulse at count==pulse_at
  task automatic sweep(input int pulse_at, output int done_edge, output int ndone,
                       output int nbusy);
    int exp_idx;
    done_edge = -1;
    ndone     = 0;
    nbusy     = 0;
    exp_idx   = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int e = 0; e < 30; e++) begin
      if (e > 0) @(posedge clk);
      @(negedge clk);
      start = (pulse_at >= 0 && int'(count) == pulse_at) ? 1'b1 : 1'b0;
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (done_edge < 0) done_edge = e;
      end
`ifdef CORR_STREAM_EN
      if (res_valid) begin
        n_cmp++;
        if (int'(res_lag) !== exp_idx) begin
          n_bad++;
          $display("FAIL stream_lag: got %0d expected %0d", res_lag, exp_idx);
        end
        n_cmp++;
        if (res_data !== model(mode, exp_idx)) begin
          n_bad++;
          $display("FAIL stream_data lag %0d: got %0d expected %0d", exp_idx, res_data,
                   model(mode, exp_idx));
        end
        exp_idx++;
      end
`endif
    end
    n_res = exp_idx;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got count=%0d busy=%0b done=%0b expected 0/0/0",
               count, busy, done);
    end
    n_cmp++;
    if (peak_val !== 8'd0 || peak_lag !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_peak: got val=%0d lag=%0d expected 0/0", peak_val, peak_lag);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_triangle();
    int de, nd, nb;
    mode = 0;
    sweep(-1, de, nd, nb);
    n_cmp++;
    if (de !== 16) begin
      n_bad++;
      $display("FAIL tri_done_edge: got %0d expected 16", de);
    end
    n_cmp++;
    if (nd !== 1) begin
      n_bad++;
      $display("FAIL tri_done_count: got %0d expected 1", nd);
    end
    n_cmp++;
    if (nb !== 16) begin
      n_bad++;
      $display("FAIL tri_busy_cycles: got %0d expected 16", nb);
    end
    n_cmp++;
    if (peak_val !== 8'd21 || peak_lag !== 4'd7) begin
      n_bad++;
      $display("FAIL tri_peak: got val=%0d lag=%0d expected 21/7", peak_val, peak_lag);
    end
    n_cmp++;
    if (count !== 4'd0) begin
      n_bad++;
      $display("FAIL tri_count_idle: got %0d expected 0", count);
    end
`ifdef CORR_STREAM_EN
    n_cmp++;
    if (n_res !== 15) begin
      n_bad++;
      $display("FAIL stream_pulses: got %0d expected 15", n_res);
    end
`endif
  endtask

  task automatic test_constant();
    int de, nd, nb;
    mode = 1;
    sweep(-1, de, nd, nb);
    n_cmp++;
    if (nd !== 1 || de !== 16) begin
      n_bad++;
      $display("FAIL const_done: got count=%0d edge=%0d expected 1/16", nd, de);
    end
    n_cmp++;
    if (peak_val !== 8'd5 || peak_lag !== 4'd0) begin
      n_bad++;
      $display("FAIL const_peak: got val=%0d lag=%0d expected 5/0", peak_val, peak_lag);
    end
  endtask

  task automatic test_spike();
    int de, nd, nb;
    mode = 2;
    sweep(-1, de, nd, nb);
    n_cmp++;
    if (nd !== 1 || de !== 16) begin
      n_bad++;
      $display("FAIL spike_done: got count=%0d edge=%0d expected 1/16", nd, de);
    end
    n_cmp++;
    if (peak_val !== 8'd200 || peak_lag !== 4'd14) begin
      n_bad++;
      $display("FAIL spike_peak: got val=%0d lag=%0d expected 200/14", peak_val, peak_lag);
    end
  endtask

  task automatic test_reset_mid();
    int de, nd, nb, wait_cnt, nd_after;
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cnt = 0;
    while (count !== 4'd4 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    n_cmp++;
    if (count !== 4'd4) begin
      n_bad++;
      $display("FAIL rstmid_reach: got count=%0d expected 4", count);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || count !== 4'd0 || peak_val !== 8'd0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_state: got busy=%0b count=%0d peak=%0d done=%0b expected 0/0/0/0",
               busy, count, peak_val, done);
    end
    reset = 1'b0;
    nd_after = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) nd_after++;
    end
    n_cmp++;
    if (nd_after !== 0) begin
      n_bad++;
      $display("FAIL rstmid_no_done: got %0d done pulses expected 0", nd_after);
    end
    sweep(-1, de, nd, nb);
    n_cmp++;
    if (nd !== 1 || de !== 16 || nb !== 16) begin
      n_bad++;
      $display("FAIL rstmid_resweep: got done=%0d edge=%0d busy=%0d expected 1/16/16",
               nd, de, nb);
    end
    n_cmp++;
    if (peak_val !== 8'd21 || peak_lag !== 4'd7) begin
      n_bad++;
      $display("FAIL rstmid_peak: got val=%0d lag=%0d expected 21/7", peak_val, peak_lag);
    end
  endtask

  task automatic test_start_ignored();
    int de, nd, nb;
    mode = 1;
    sweep(6, de, nd, nb);
    n_cmp++;
    if (nd !== 1 || de !== 16 || nb !== 16) begin
      n_bad++;
      $display("FAIL ignore_start: got done=%0d edge=%0d busy=%0d expected 1/16/16",
               nd, de, nb);
    end
  endtask

  task automatic test_back_to_back();
    int d0, d1, nd, idle;
    d0   = -1;
    d1   = -1;
    nd   = 0;
    idle = 0;
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int e = 0; e < 45; e++) begin
      if (e > 0) @(posedge clk);
      @(negedge clk);
      if (done) begin
        nd++;
        if (d0 < 0) d0 = e;
        else if (d1 < 0) d1 = e;
      end else if (!busy && d0 >= 0 && d1 < 0) begin
        idle++;
      end
    end
    start = 1'b0;
    n_cmp++;
    if (d0 !== 16 || d1 !== 34) begin
      n_bad++;
      $display("FAIL b2b_done_edges: got %0d,%0d expected 16,34", d0, d1);
    end
    n_cmp++;
    if (idle !== 1) begin
      n_bad++;
      $display("FAIL b2b_idle_cycles: got %0d expected 1", idle);
    end
    repeat (25) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || peak_val !== 8'd21 || peak_lag !== 4'd7) begin
      n_bad++;
      $display("FAIL b2b_final: got busy=%0b val=%0d lag=%0d expected 0/21/7",
               busy, peak_val, peak_lag);
    end
  endtask

  initial begin
    start = 1'b0;
    reset = 1'b1;
    test_reset();
    test_triangle();
    test_constant();
    test_spike();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
